// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter serialising load/store (client 0) and fetch
// (client 1) onto one memory port with a single outstanding transaction.
//
//   state   | meaning
//   st_idle | nothing in flight; grant a pending or same-edge incoming request
//   st_wait | granted request issued to memory; waiting for mem_ack
module mem_arbiter #(
  parameter int addr_width = 32,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c0_rd_req,
  input  logic                  c0_wr_req,
  input  logic [addr_width-1:0] c0_addr,
  input  logic [data_width-1:0] c0_wr_data,
  output logic [data_width-1:0] c0_rd_data,
  output logic                  c0_busy,
  output logic                  c0_ack,
  input  logic                  c1_rd_req,
  input  logic                  c1_wr_req,
  input  logic [addr_width-1:0] c1_addr,
  input  logic [data_width-1:0] c1_wr_data,
  output logic [data_width-1:0] c1_rd_data,
  output logic                  c1_busy,
  output logic                  c1_ack,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wr_data,
  input  logic [data_width-1:0] mem_rd_data,
  input  logic                  mem_busy,
  input  logic                  mem_ack
);

  typedef enum logic {st_idle, st_wait} state_t;

  state_t state_q, state_d;

  logic [1:0]                 req_rd, req_wr;
  logic [1:0][addr_width-1:0] req_addr;
  logic [1:0][data_width-1:0] req_wdata;

  logic [1:0]                 slot_vld_q, slot_vld_d;
  logic [1:0]                 slot_wr_q, slot_wr_d;
  logic [1:0][addr_width-1:0] slot_addr_q, slot_addr_d;
  logic [1:0][data_width-1:0] slot_wdata_q, slot_wdata_d;

  logic grant_q, grant_d;
  logic last_q, last_d;
  logic sel;

  logic                  mem_rd_req_q, mem_rd_req_d;
  logic                  mem_wr_req_q, mem_wr_req_d;
  logic [addr_width-1:0] mem_addr_q, mem_addr_d;
  logic [data_width-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]                 ack_q, ack_d;
  logic [1:0][data_width-1:0] rd_data_q, rd_data_d;

  logic unused_mem_busy;

  assign unused_mem_busy = mem_busy;

  assign req_rd    = {c1_rd_req, c0_rd_req};
  assign req_wr    = {c1_wr_req, c0_wr_req};
  assign req_addr  = {c1_addr, c0_addr};
  assign req_wdata = {c1_wr_data, c0_wr_data};

  always_comb begin
    state_d      = state_q;
    slot_vld_d   = slot_vld_q;
    slot_wr_d    = slot_wr_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    grant_d      = grant_q;
    last_d       = last_q;
    sel          = 1'b0;
    mem_rd_req_d = 1'b0;
    mem_wr_req_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ack_d        = '0;
    rd_data_d    = '0;

    // A pulse from a client whose slot is occupied is a protocol violation and is dropped.
    for (int i = 0; i < 2; i++) begin
      if (!slot_vld_q[i] && (req_rd[i] || req_wr[i])) begin
        slot_vld_d[i]   = 1'b1;
        slot_wr_d[i]    = req_wr[i];
        slot_addr_d[i]  = req_addr[i];
        slot_wdata_d[i] = req_wdata[i];
      end
    end

    unique case (state_q)
      st_idle: begin
        if (slot_vld_d != 2'b00) begin
          sel          = (slot_vld_d == 2'b11) ? ~last_q : slot_vld_d[1];
          grant_d      = sel;
          last_d       = sel;
          mem_addr_d   = slot_addr_d[sel];
          mem_wdata_d  = slot_wdata_d[sel];
          mem_wr_req_d = slot_wr_d[sel];
          mem_rd_req_d = ~slot_wr_d[sel];
          state_d      = st_wait;
        end
      end
      st_wait: begin
        if (mem_ack) begin
          ack_d[grant_q] = 1'b1;
          if (!slot_wr_q[grant_q]) rd_data_d[grant_q] = mem_rd_data;
          slot_vld_d[grant_q] = 1'b0;
          state_d = st_idle;
        end
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= st_idle;
      slot_vld_q   <= '0;
      slot_wr_q    <= '0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ack_q        <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      slot_vld_q   <= slot_vld_d;
      slot_wr_q    <= slot_wr_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ack_q        <= ack_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign c0_busy     = slot_vld_q[0];
  assign c1_busy     = slot_vld_q[1];
  assign c0_ack      = ack_q[0];
  assign c1_ack      = ack_q[1];
  assign c0_rd_data  = rd_data_q[0];
  assign c1_rd_data  = rd_data_q[1];
  assign mem_rd_req  = mem_rd_req_q;
  assign mem_wr_req  = mem_wr_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: delayed memory model, per-client expectation queues
// popped on each client ack, and one task per scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c0_rd_req = 1'b0, c0_wr_req = 1'b0;
  logic [31:0] c0_addr = '0, c0_wr_data = '0, c0_rd_data;
  logic        c0_busy, c0_ack;
  logic        c1_rd_req = 1'b0, c1_wr_req = 1'b0;
  logic [31:0] c1_addr = '0, c1_wr_data = '0, c1_rd_data;
  logic        c1_busy, c1_ack;
  logic        mem_rd_req, mem_wr_req, mem_busy, mem_ack;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.addr_width(32), .data_width(32)) dut (
    .clk(clk), .rst(rst),
    .c0_rd_req(c0_rd_req), .c0_wr_req(c0_wr_req), .c0_addr(c0_addr),
    .c0_wr_data(c0_wr_data), .c0_rd_data(c0_rd_data), .c0_busy(c0_busy), .c0_ack(c0_ack),
    .c1_rd_req(c1_rd_req), .c1_wr_req(c1_wr_req), .c1_addr(c1_addr),
    .c1_wr_data(c1_wr_data), .c1_rd_data(c1_rd_data), .c1_busy(c1_busy), .c1_ack(c1_ack),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_busy(mem_busy),
    .mem_ack(mem_ack)
  );

  // Delayed memory: down-counter latency, ack pulse on terminal count.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [3:0]  m_cnt;
  logic        m_busy, m_ack, m_is_wr;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic        spur_ack = 1'b0;
  logic [31:0] spur_data = '0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  assign mem_ack     = m_ack | spur_ack;
  assign mem_rd_data = m_rdata | spur_data;
  assign mem_busy    = m_busy;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (rst) begin
      m_cnt   <= '0;
      m_busy  <= 1'b0;
      m_ack   <= 1'b0;
      m_rdata <= '0;
    end else begin
      m_ack   <= 1'b0;
      m_rdata <= '0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 4'd1;
        if (m_cnt == 4'd1) begin
          m_ack  <= 1'b1;
          m_busy <= 1'b0;
          if (m_is_wr) mem[m_addr[9:2]] <= m_wdata;
          else         m_rdata <= mem[m_addr[9:2]];
        end
      end else if (mem_rd_req || mem_wr_req) begin
        m_cnt   <= 4'd3;
        m_busy  <= 1'b1;
        m_is_wr <= mem_wr_req;
        m_addr  <= mem_addr;
        m_wdata <= mem_wr_data;
      end
    end
  end

  // Scoreboard: expected rd_data per client (0 for writes), pushed at request time.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int ack_cnt0 = 0, ack_cnt1 = 0;
  int mrd_cnt = 0, mwr_cnt = 0;
  int mrd_cyc = -1, mwr_cyc = -1, memack_cyc = -1;
  logic [31:0] mrd_addr = '0, mwr_addr = '0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (mem_rd_req) begin mrd_cyc = cyc; mrd_addr = mem_addr; mrd_cnt++; end
      if (mem_wr_req) begin mwr_cyc = cyc; mwr_addr = mem_addr; mwr_cnt++; end
      if (mem_ack) memack_cyc = cyc;
      checks++;
      if (c0_ack) begin
        ack_cnt0++;
        if (exp_q0.size() == 0) begin
          errors++; $display("FAIL c0_unexpected_ack cyc=%0d rd_data=%h required no ack", cyc, c0_rd_data);
        end else begin
          e = exp_q0.pop_front();
          if (c0_rd_data !== e) begin
            errors++; $display("FAIL c0_rd_data got=%h exp=%h", c0_rd_data, e);
          end
        end
      end else if (c0_rd_data !== 32'h0) begin
        errors++; $display("FAIL c0_rd_data_idle got=%h exp=0", c0_rd_data);
      end
      checks++;
      if (c1_ack) begin
        ack_cnt1++;
        if (exp_q1.size() == 0) begin
          errors++; $display("FAIL c1_unexpected_ack cyc=%0d rd_data=%h required no ack", cyc, c1_rd_data);
        end else begin
          e = exp_q1.pop_front();
          if (c1_rd_data !== e) begin
            errors++; $display("FAIL c1_rd_data got=%h exp=%h", c1_rd_data, e);
          end
        end
      end else if (c1_rd_data !== 32'h0) begin
        errors++; $display("FAIL c1_rd_data_idle got=%h exp=0", c1_rd_data);
      end
    end
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] d);
    pl_idx = idx; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Drives a request for the coming edge and pushes its expected result.
  task automatic set_req(input int c, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
    logic [31:0] e;
    checks++;
    if ((c == 0 ? c0_busy : c1_busy) !== 1'b0) begin
      errors++; $display("FAIL protocol_pulse_while_busy client=%0d busy=1 required 0", c);
    end
    if (wr) begin e = '0; ref_mem[a[9:2]] = d; end
    else e = ref_mem[a[9:2]];
    if (c == 0) begin
      c0_rd_req = rd; c0_wr_req = wr; c0_addr = a; c0_wr_data = d; exp_q0.push_back(e);
    end else begin
      c1_rd_req = rd; c1_wr_req = wr; c1_addr = a; c1_wr_data = d; exp_q1.push_back(e);
    end
  endtask

  task automatic fire(output int rc);
    @(posedge clk); #1;
    c0_rd_req = 1'b0; c0_wr_req = 1'b0; c1_rd_req = 1'b0; c1_wr_req = 1'b0;
    rc = cyc;
  endtask

  // Returns at the negedge of the first ack cycle of a wanted client (who=-1 on timeout).
  task automatic wait_ack(input bit w0, input bit w1, input int budget,
                          output int who, output bit busy_ok);
    who = -1; busy_ok = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (w0 && c0_ack) begin who = 0; break; end
      if (w1 && c1_ack) begin who = 1; break; end
      if ((w0 && !c0_busy) || (w1 && !c1_busy)) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({c0_busy, c0_ack, c0_rd_data} !== '0) begin
      errors++; $display("FAIL reset_c0 got=%h exp=0", {c0_busy, c0_ack, c0_rd_data});
    end
    checks++;
    if ({c1_busy, c1_ack, c1_rd_data} !== '0) begin
      errors++; $display("FAIL reset_c1 got=%h exp=0", {c1_busy, c1_ack, c1_rd_data});
    end
    checks++;
    if ({mem_rd_req, mem_wr_req, mem_addr, mem_wr_data} !== '0) begin
      errors++; $display("FAIL reset_mem got=%h exp=0", {mem_rd_req, mem_wr_req, mem_addr, mem_wr_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int rc, who, n1, nwr;
    bit bok;
    preload(8'h10, 32'h1234);
    n1 = ack_cnt1; nwr = mwr_cnt;
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
    fire(rc);
    @(negedge clk);
    checks++;
    if (mem_rd_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL single_mem_pulse rd_req=%b addr=%h exp 1/00000040", mem_rd_req, mem_addr);
    end
    wait_ack(1'b1, 1'b0, 40, who, bok);
    checks++;
    if (who !== 0) begin errors++; $display("FAIL single_ack who=%0d exp=0", who); end
    checks++;
    if (!bok) begin errors++; $display("FAIL single_busy_throughout got=0 exp=1"); end
    checks++;
    if (c0_busy !== 1'b0 || c0_rd_data !== 32'h1234) begin
      errors++; $display("FAIL single_ack_cycle busy=%b rd_data=%h exp 0/00001234", c0_busy, c0_rd_data);
    end
    checks++;
    if (cyc != memack_cyc + 1) begin
      errors++; $display("FAIL single_ack_latency ack_cyc=%0d exp=%0d", cyc, memack_cyc + 1);
    end
    checks++;
    if (c1_busy !== 1'b0 || ack_cnt1 != n1 || mwr_cnt != nwr) begin
      errors++; $display("FAIL single_quiet c1_busy=%b c1_acks=%0d mem_wr=%0d exp 0/%0d/%0d",
                         c1_busy, ack_cnt1, mwr_cnt, n1, nwr);
    end
  endtask

  task automatic test_write_read();
    int rc, who, n0, a1;
    bit bok;
    @(posedge clk); #1;
    n0 = ack_cnt0;
    set_req(1, 1'b0, 1'b1, 32'h8, 32'hdeadbeef);
    fire(rc);
    wait_ack(1'b0, 1'b1, 40, who, bok);
    checks++;
    if (who !== 1 || !bok) begin errors++; $display("FAIL wr_ack who=%0d busy_ok=%b exp 1/1", who, bok); end
    a1 = cyc;
    set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
    fire(rc);
    wait_ack(1'b0, 1'b1, 40, who, bok);
    checks++;
    if (who !== 1 || c1_rd_data !== 32'hdeadbeef) begin
      errors++; $display("FAIL rd_back who=%0d data=%h exp 1/deadbeef", who, c1_rd_data);
    end
    checks++;
    if (mrd_cyc != a1 + 1 || mrd_addr !== 32'h8) begin
      errors++; $display("FAIL back_to_back mem_rd cyc=%0d addr=%h exp %0d/00000008", mrd_cyc, mrd_addr, a1 + 1);
    end
    checks++;
    if (ack_cnt0 != n0) begin errors++; $display("FAIL wr_rd_c0_quiet acks=%0d exp=%0d", ack_cnt0, n0); end
  endtask

  task automatic collide(input int first, input int round);
    int rc, who, a0;
    bit bok;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0);
    fire(rc);
    wait_ack(1'b1, 1'b1, 60, who, bok);
    checks++;
    if (who !== first) begin errors++; $display("FAIL collide%0d_first who=%0d exp=%0d", round, who, first); end
    checks++;
    if ((first == 0 ? c1_busy : c0_busy) !== 1'b1) begin
      errors++; $display("FAIL collide%0d_other_busy got=0 exp=1", round);
    end
    a0 = cyc;
    wait_ack(first == 1, first == 0, 60, who, bok);
    checks++;
    if (who !== 1 - first) begin errors++; $display("FAIL collide%0d_second who=%0d exp=%0d", round, who, 1 - first); end
    checks++;
    if (mrd_cyc != a0 + 1 || mrd_addr !== (first == 0 ? 32'h20 : 32'h10)) begin
      errors++; $display("FAIL collide%0d_second_issue cyc=%0d addr=%h exp cyc %0d", round, mrd_cyc, mrd_addr, a0 + 1);
    end
  endtask

  task automatic test_collision();
    int rc, who;
    bit bok;
    preload(8'h04, 32'h0000_1010);
    preload(8'h08, 32'h0000_2020);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    collide(0, 1);
    // A lone client-0 grant makes client 1 the favourite of the next tie.
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    fire(rc);
    wait_ack(1'b1, 1'b0, 40, who, bok);
    checks++;
    if (who !== 0) begin errors++; $display("FAIL collide_single who=%0d exp=0", who); end
    collide(1, 2);
  endtask

  task automatic test_capture_wait();
    int rc, who, a0;
    bit hold_ok, bok;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
    fire(rc);
    set_req(1, 1'b0, 1'b1, 32'h30, 32'hcafef00d);
    fire(rc);
    @(negedge clk);
    checks++;
    if (c1_busy !== 1'b1) begin errors++; $display("FAIL capture_busy got=%b exp=1", c1_busy); end
    hold_ok = 1'b1; who = -1;
    for (int i = 0; i < 40; i++) begin
      if (c0_ack) begin who = 0; break; end
      if (mem_addr !== 32'h40 || mem_rd_req || mem_wr_req) hold_ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (who !== 0 || !hold_ok || mem_addr !== 32'h40) begin
      errors++; $display("FAIL capture_hold who=%0d hold_ok=%b addr=%h exp 0/1/00000040", who, hold_ok, mem_addr);
    end
    a0 = cyc;
    wait_ack(1'b0, 1'b1, 40, who, bok);
    checks++;
    if (who !== 1 || !bok) begin errors++; $display("FAIL capture_c1_ack who=%0d busy_ok=%b exp 1/1", who, bok); end
    checks++;
    if (mwr_cyc != a0 + 1 || mwr_addr !== 32'h30) begin
      errors++; $display("FAIL capture_issue cyc=%0d addr=%h exp %0d/00000030", mwr_cyc, mwr_addr, a0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    int rc, who, n0;
    bit bok;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
    fire(rc);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({c0_busy, c0_ack, c0_rd_data, c1_busy, c1_ack, c1_rd_data,
         mem_rd_req, mem_wr_req, mem_addr, mem_wr_data} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs c0_busy=%b mem_addr=%h exp all 0", c0_busy, mem_addr);
    end
    n0 = ack_cnt0;
    repeat (15) @(negedge clk);
    checks++;
    if (ack_cnt0 != n0 || c0_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_abandon acks=%0d busy=%b exp %0d/0", ack_cnt0, c0_busy, n0);
    end
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
    fire(rc);
    wait_ack(1'b0, 1'b1, 40, who, bok);
    checks++;
    if (who !== 1 || c1_rd_data !== 32'h1234) begin
      errors++; $display("FAIL reset_mid_fresh who=%0d data=%h exp 1/00001234", who, c1_rd_data);
    end
  endtask

  task automatic test_spurious();
    int rc, who, n0, n1, nrd;
    bit bok;
    @(posedge clk); #1;
    n0 = ack_cnt0; n1 = ack_cnt1; nrd = mrd_cnt;
    spur_ack = 1'b1; spur_data = 32'h5555_aaaa;
    @(posedge clk); #1;
    spur_ack = 1'b0; spur_data = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (ack_cnt0 != n0 || ack_cnt1 != n1) begin
      errors++; $display("FAIL spurious_idle acks=%0d/%0d exp %0d/%0d", ack_cnt0, ack_cnt1, n0, n1);
    end
    @(posedge clk); #1;
    spur_ack = 1'b1; spur_data = 32'h1111_2222;
    set_req(0, 1'b1, 1'b1, 32'h50, 32'ha5a5a5a5);
    fire(rc);
    spur_ack = 1'b0; spur_data = '0;
    @(negedge clk);
    checks++;
    if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0 || mem_addr !== 32'h50 || mem_wr_data !== 32'ha5a5a5a5) begin
      errors++; $display("FAIL wr_wins wr=%b rd=%b addr=%h data=%h exp 1/0/00000050/a5a5a5a5",
                         mem_wr_req, mem_rd_req, mem_addr, mem_wr_data);
    end
    wait_ack(1'b1, 1'b0, 40, who, bok);
    checks++;
    if (who !== 0 || c0_rd_data !== 32'h0 || ack_cnt1 != n1) begin
      errors++; $display("FAIL wr_wins_ack who=%0d data=%h exp 0/00000000", who, c0_rd_data);
    end
    checks++;
    if (mrd_cnt != nrd) begin errors++; $display("FAIL read_dropped mem_rd=%0d exp=%0d", mrd_cnt, nrd); end
    set_req(0, 1'b1, 1'b0, 32'h50, 32'h0);
    fire(rc);
    wait_ack(1'b1, 1'b0, 40, who, bok);
    checks++;
    if (who !== 0 || c0_rd_data !== 32'ha5a5a5a5) begin
      errors++; $display("FAIL wr_wins_readback who=%0d data=%h exp 0/a5a5a5a5", who, c0_rd_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_collision();
    test_capture_wait();
    test_reset_mid();
    test_spurious();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d/%0d exp 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client arbiter directly upstream of the delayed memory model.
- Client 0 is the load/store path; client 1 is instruction fetch.
- Each client uses the same single-pulse rd_req/wr_req, busy/ack handshake as the memory. The block serialises the clients onto the single memory port, one outstanding transaction at a time, with round-robin fairness.

Parameters:
- addr_width, 32, byte address width (word-aligned; bits [1:0] passed through untouched).
- data_width, 32, data word width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- c0_rd_req  input  1  client 0 read request pulse.
- c0_wr_req  input  1  client 0 write request pulse.
- c0_addr  input  addr_width  client 0 address, sampled on request cycle.
- c0_wr_data  input  data_width  client 0 write data, sampled on request cycle.
- c0_rd_data  output  data_width  client 0 read data, valid only while c0_ack=1, else 0.
- c0_busy  output  1  client 0 request accepted and not yet acked.
- c0_ack  output  1  client 0 completion pulse.
- c1_rd_req, c1_wr_req, c1_addr, c1_wr_data, c1_rd_data, c1_busy, c1_ack: same as client 0.
- mem_rd_req  output  1  read pulse to memory.
- mem_wr_req  output  1  write pulse to memory.
- mem_addr  output  addr_width  address to memory.
- mem_wr_data  output  data_width  write data to memory.
- mem_rd_data  input  data_width  memory read data, valid with mem_ack.
- mem_busy  input  1  memory busy (monitor only; not used for flow control).
- mem_ack  input  1  memory completion pulse.

Behaviour:
- Reset (synchronous):
  - All outputs are 0. mem_addr and mem_wr_data are 0.
  - Both pending slots are cleared; state is IDLE; last_grant = 1, so client 0 wins the first tie.
  - Reset mid-transaction abandons the outstanding request with no ack to any client. The memory is reset on the same rst.
- Capture:
  - A request pulse on edge E is captured into that client's pending slot (type, addr, wr_data). cN_busy goes 1 from the cycle after E.
  - If a client asserts wr_req and rd_req together, the write wins and the read is dropped.
  - A new pulse from a client whose slot is pending or in flight is a protocol violation: it is ignored, and the bench asserts it never occurs.
- State machine IDLE -> WAIT -> IDLE:
  - IDLE, at each edge: the candidates are pending slots plus same-edge incoming pulses.
    - One candidate: it is granted.
    - Two candidates: the client != last_grant is granted.
    - On grant: mem_addr and mem_wr_data are loaded, the matching mem_rd_req or mem_wr_req goes 1 for exactly one cycle, last_grant is updated, and state moves to WAIT.
  - WAIT:
    - mem_addr and mem_wr_data are held stable; no new mem request is issued.
    - Requests from the other client are captured into its slot.
    - On an edge where mem_ack=1: the granted client's ack goes 1 for one cycle and its busy goes 0 in that same cycle. For reads, cN_rd_data = mem_rd_data latched at that edge. The slot is freed and state returns to IDLE.
  - The next grant happens on the edge after the ack cycle begins, so there is 1 dead cycle between transactions.
- Latency:
  - Request at edge E produces a mem pulse in cycle E+1.
  - Client ack comes 1 cycle after mem_ack.
  - The arbiter adds 2 cycles of latency in total.
- mem_ack while IDLE is spurious: it is ignored and no client ack is produced.
- The non-granted client's ack and rd_data stay 0. cN_rd_data is 0 on write acks.
- Both clients can be busy at once (one in flight, one pending). Starvation is impossible: a pending client is served next.

Test Plan:
- Single read: preload mem[0x40>>2]=0x1234; c0_rd_req with c0_addr=0x40. Expect mem_rd_req pulse 1 cycle later with mem_addr=0x40, then c0_ack=1 with c0_rd_data=0x1234 one cycle after mem_ack. c0_busy is high throughout and low in the ack cycle. c1 outputs stay 0.
- Write then read: c1_wr_req addr=0x8 data=0xdeadbeef, then after c1_ack, c1_rd_req addr=0x8. Expect c1_rd_data=0xdeadbeef, and c0_ack never asserted.
- Simultaneous requests after reset: c0_rd 0x10 and c1_rd 0x20 on the same edge. Expect c0 granted first, c1's mem_rd_req exactly 1 cycle after c0_ack. Repeat the collision: c1 granted first (round-robin).
- Capture during WAIT: while c0 is in flight, c1_wr_req pulses once. Expect c1_busy=1 from the next cycle, mem_addr unchanged until c0_ack, then c1 issued.
- Reset mid-WAIT: assert rst for 1 cycle while c0 is in flight. Expect all outputs 0 next cycle, no c0_ack ever, and a fresh c1 read completing normally afterwards.
- Spurious mem_ack in IDLE with wr+rd asserted together on c0: expect no client ack from the spurious pulse; mem_wr_req only, with no mem_rd_req.
